posit_adder_pipe: RTL and testbench



---
 rtl/posit_adder_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_posit_adder_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_adder_pipe.sv
`timescale 1ns/1ps
// posit_adder_pipe: three-stage posit add/sub on decoded fields.
// Stage 1 compares and swaps the operands, stage 2 aligns and adds,
// stage 3 normalises. The result is unrounded and comes with guard, round
// and sticky bits for the encoder. One global enable stalls all stages
// together while the output is held.
//
// state | meaning
// ------+-------------------------------------------------------------
// (none) | straight pipeline with no FSM; r1/r2/r3 valid bits mark
//        | which stages hold a live operation
module posit_adder_pipe #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 1,
  localparam int FW = POSIT_WIDTH - 3 - POSIT_ES,
  localparam int SW = $clog2(POSIT_WIDTH - 1) + POSIT_ES + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op1_sign,
  input  logic                 op1_nar,
  input  logic                 op1_zero,
  input  logic signed [SW-1:0] op1_scale,
  input  logic [FW-1:0]        op1_fraction,
  input  logic                 op2_sign,
  input  logic                 op2_nar,
  input  logic                 op2_zero,
  input  logic signed [SW-1:0] op2_scale,
  input  logic [FW-1:0]        op2_fraction,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 res_sign,
  output logic                 res_nar,
  output logic                 res_zero,
  output logic signed [SW:0]   res_scale,
  output logic [FW-1:0]        res_fraction,
  output logic                 res_guard,
  output logic                 res_round,
  output logic                 res_sticky
);

  // Significand with hidden bit and three extra bits for guard/round/sticky.
  localparam int MW   = FW + 4;
  localparam int SUMW = FW + 5;
  localparam int SW1  = SW + 1;
  localparam int LZW  = $clog2(MW + 1);
  localparam logic [SW1-1:0] C_MAX_SHIFT = SW1'(MW);

  // Position of the leading one, counted from the MSB.
  function automatic logic [LZW-1:0] f_lzc(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && v[i]) found = 1'b1;
      else if (!found)    n = n + 1'b1;
    end
    return n;
  endfunction

  logic w_en;

  // Stage 1 registers
  logic           r1_valid, r1_sign, r1_op, r1_nar, r1_both_zero, r1_pass;
  logic [SW-1:0]  r1_l_scale;
  logic [FW-1:0]  r1_l_frac, r1_s_frac;
  logic [SW1-1:0] r1_shift;

  // Stage 2 registers
  logic            r2_valid, r2_sign, r2_nar, r2_both_zero, r2_pass;
  logic [SW-1:0]   r2_l_scale;
  logic [FW-1:0]   r2_l_frac;
  logic [SUMW-1:0] r2_sum;

  // Stage 3 (output) registers
  logic           r3_valid, r3_sign, r3_nar, r3_zero, r3_guard, r3_round, r3_sticky;
  logic [SW1-1:0] r3_scale;
  logic [FW-1:0]  r3_frac;

  assign w_en     = !r3_valid | out_ready;
  assign in_ready = w_en;

  // Stage 1 comparison and swap
  logic           w_op2_sign_eff, w_op2_gt, w_swap;
  logic           w_l_sign, w_s_sign;
  logic [SW-1:0]  w_l_scale, w_s_scale;
  logic [FW-1:0]  w_l_frac, w_s_frac;
  logic [SW1-1:0] w_shift;

  assign w_op2_sign_eff = op2_sign ^ sub;
  assign w_op2_gt = (op2_scale > op1_scale) ||
                    ((op2_scale == op1_scale) && (op2_fraction > op1_fraction));
  // A zero operand never becomes L, so a single non-zero operand passes through.
  assign w_swap    = op1_zero ? 1'b1 : (op2_zero ? 1'b0 : w_op2_gt);
  assign w_l_sign  = w_swap ? w_op2_sign_eff : op1_sign;
  assign w_s_sign  = w_swap ? op1_sign       : w_op2_sign_eff;
  assign w_l_scale = w_swap ? op2_scale      : op1_scale;
  assign w_s_scale = w_swap ? op1_scale      : op2_scale;
  assign w_l_frac  = w_swap ? op2_fraction   : op1_fraction;
  assign w_s_frac  = w_swap ? op1_fraction   : op2_fraction;
  assign w_shift   = {w_l_scale[SW-1], w_l_scale} - {w_s_scale[SW-1], w_s_scale};

  // Stage 1 register: ordered operands, shift distance and special-case flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid     <= 1'b0;
      r1_sign      <= 1'b0;
      r1_op        <= 1'b0;
      r1_nar       <= 1'b0;
      r1_both_zero <= 1'b0;
      r1_pass      <= 1'b0;
      r1_l_scale   <= '0;
      r1_l_frac    <= '0;
      r1_s_frac    <= '0;
      r1_shift     <= '0;
    end else if (w_en) begin
      r1_valid     <= in_valid;
      r1_sign      <= w_l_sign;
      r1_op        <= (w_l_sign == w_s_sign);
      r1_nar       <= op1_nar | op2_nar;
      r1_both_zero <= op1_zero & op2_zero;
      r1_pass      <= op1_zero ^ op2_zero;
      r1_l_scale   <= w_l_scale;
      r1_l_frac    <= w_l_frac;
      r1_s_frac    <= w_s_frac;
      r1_shift     <= w_shift;
    end
  end

  // Stage 2 alignment with sticky collection, then add/subtract
  logic [SW1-1:0]  w_amt;
  logic [MW-1:0]   w_s_sig, w_l_sig, w_s_shr, w_lost_mask, w_s_al;
  logic            w_align_sticky;
  logic [SUMW-1:0] w_sum;

  assign w_amt          = (r1_shift > C_MAX_SHIFT) ? C_MAX_SHIFT : r1_shift;
  assign w_s_sig        = {1'b1, r1_s_frac, 3'b000};
  assign w_l_sig        = {1'b1, r1_l_frac, 3'b000};
  assign w_s_shr        = w_s_sig >> w_amt;
  assign w_lost_mask    = ~({MW{1'b1}} << w_amt);
  assign w_align_sticky = |(w_s_sig & w_lost_mask);
  assign w_s_al         = w_s_shr | {{(MW-1){1'b0}}, w_align_sticky};
  // L magnitude >= aligned S, so the difference never goes negative.
  assign w_sum = r1_op ? ({1'b0, w_l_sig} + {1'b0, w_s_al})
                       : ({1'b0, w_l_sig} - {1'b0, w_s_al});

  // Stage 2 register: raw sum plus the fields needed for pass-through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid     <= 1'b0;
      r2_sign      <= 1'b0;
      r2_nar       <= 1'b0;
      r2_both_zero <= 1'b0;
      r2_pass      <= 1'b0;
      r2_l_scale   <= '0;
      r2_l_frac    <= '0;
      r2_sum       <= '0;
    end else if (w_en) begin
      r2_valid     <= r1_valid;
      r2_sign      <= r1_sign;
      r2_nar       <= r1_nar;
      r2_both_zero <= r1_both_zero;
      r2_pass      <= r1_pass;
      r2_l_scale   <= r1_l_scale;
      r2_l_frac    <= r1_l_frac;
      r2_sum       <= w_sum;
    end
  end

  // Stage 3 normalisation
  logic           w_carry, w_sum_is_zero;
  logic [LZW-1:0] w_lzc;
  logic [MW-1:0]  w_shl;
  logic [MW-2:0]  w_frac_grs;
  logic [SW1-1:0] w_l_scale_ext, w_norm_scale;

  assign w_carry       = r2_sum[SUMW-1];
  assign w_lzc         = f_lzc(r2_sum[MW-1:0]);
  assign w_shl         = r2_sum[MW-1:0] << w_lzc;
  // After shifting by the LZC the MSB is set unless the sum cancelled to zero.
  assign w_sum_is_zero = !w_carry && !w_shl[MW-1];
  assign w_l_scale_ext = {r2_l_scale[SW-1], r2_l_scale};
  assign w_frac_grs    = w_carry ? {r2_sum[SUMW-2:2], r2_sum[1] | r2_sum[0]}
                                 : w_shl[MW-2:0];
  assign w_norm_scale  = w_carry ? (w_l_scale_ext + {{(SW1-1){1'b0}}, 1'b1})
                                 : (w_l_scale_ext - {{(SW1-LZW){1'b0}}, w_lzc});

  logic           w_n_sign, w_n_nar, w_n_zero, w_n_guard, w_n_round, w_n_sticky;
  logic [SW1-1:0] w_n_scale;
  logic [FW-1:0]  w_n_frac;

  // Select the stage 3 result: specials take priority over arithmetic
  always_comb begin
    w_n_sign   = 1'b0;
    w_n_nar    = 1'b0;
    w_n_zero   = 1'b0;
    w_n_scale  = '0;
    w_n_frac   = '0;
    w_n_guard  = 1'b0;
    w_n_round  = 1'b0;
    w_n_sticky = 1'b0;
    if (r2_nar) begin
      w_n_nar = 1'b1;
    end else if (r2_both_zero) begin
      w_n_zero = 1'b1;
    end else if (r2_pass) begin
      w_n_sign  = r2_sign;
      w_n_scale = w_l_scale_ext;
      w_n_frac  = r2_l_frac;
    end else if (w_sum_is_zero) begin
      w_n_zero = 1'b1;
    end else begin
      w_n_sign   = r2_sign;
      w_n_scale  = w_norm_scale;
      w_n_frac   = w_frac_grs[MW-2:3];
      w_n_guard  = w_frac_grs[2];
      w_n_round  = w_frac_grs[1];
      w_n_sticky = w_frac_grs[0];
    end
  end

  // Stage 3 register: holds the result while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_valid  <= 1'b0;
      r3_sign   <= 1'b0;
      r3_nar    <= 1'b0;
      r3_zero   <= 1'b0;
      r3_scale  <= '0;
      r3_frac   <= '0;
      r3_guard  <= 1'b0;
      r3_round  <= 1'b0;
      r3_sticky <= 1'b0;
    end else if (w_en) begin
      r3_valid  <= r2_valid;
      r3_sign   <= w_n_sign;
      r3_nar    <= w_n_nar;
      r3_zero   <= w_n_zero;
      r3_scale  <= w_n_scale;
      r3_frac   <= w_n_frac;
      r3_guard  <= w_n_guard;
      r3_round  <= w_n_round;
      r3_sticky <= w_n_sticky;
    end
  end

  assign out_valid    = r3_valid;
  assign res_sign     = r3_sign;
  assign res_nar      = r3_nar;
  assign res_zero     = r3_zero;
  assign res_scale    = r3_scale;
  assign res_fraction = r3_frac;
  assign res_guard    = r3_guard;
  assign res_round    = r3_round;
  assign res_sticky   = r3_sticky;

endmodule

// File: tb/tb_posit_adder_pipe.sv
`timescale 1ns/1ps
// Bench for posit_adder_pipe<8,1>: random and directed operand pairs,
// an arithmetic reference model with a result queue, stall-hold checks,
// and a reset dropped into a running stream.
module tb_posit_adder_pipe;
  localparam int N  = 8;
  localparam int ES = 1;
  localparam int FW = N - 3 - ES;
  localparam int SW = $clog2(N - 1) + ES + 1;

  typedef struct packed {
    logic                 sign;
    logic                 nar;
    logic                 zero;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } op_t;

  typedef struct packed {
    logic               sign;
    logic               nar;
    logic               zero;
    logic signed [SW:0] scale;
    logic [FW-1:0]      frac;
    logic               g;
    logic               r;
    logic               s;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic op1_sign = 1'b0, op1_nar = 1'b0, op1_zero = 1'b0;
  logic op2_sign = 1'b0, op2_nar = 1'b0, op2_zero = 1'b0;
  logic signed [SW-1:0] op1_scale = '0, op2_scale = '0;
  logic [FW-1:0] op1_fraction = '0, op2_fraction = '0;
  logic sub = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic res_sign, res_nar, res_zero, res_guard, res_round, res_sticky;
  logic signed [SW:0] res_scale;
  logic [FW-1:0] res_fraction;

  always #5 clk = ~clk;

  posit_adder_pipe #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1_sign(op1_sign), .op1_nar(op1_nar), .op1_zero(op1_zero),
    .op1_scale(op1_scale), .op1_fraction(op1_fraction),
    .op2_sign(op2_sign), .op2_nar(op2_nar), .op2_zero(op2_zero),
    .op2_scale(op2_scale), .op2_fraction(op2_fraction),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_nar(res_nar), .res_zero(res_zero),
    .res_scale(res_scale), .res_fraction(res_fraction),
    .res_guard(res_guard), .res_round(res_round), .res_sticky(res_sticky)
  );

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  res_t cur, held, exp_r;
  op_t  a_in, b_in;
  bit   held_v = 1'b0;
  int   ready_mode = 0;
  int   pidx = 0;
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  assign cur  = {res_sign, res_nar, res_zero, res_scale, res_fraction,
                 res_guard, res_round, res_sticky};
  assign a_in = {op1_sign, op1_nar, op1_zero, op1_scale, op1_fraction};
  assign b_in = {op2_sign, op2_nar, op2_zero, op2_scale, op2_fraction};

  task automatic chk_r(input string name, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got s=%0b n=%0b z=%0b sc=%0d f=%h grs=%0b%0b%0b expected s=%0b n=%0b z=%0b sc=%0d f=%h grs=%0b%0b%0b",
               name, got.sign, got.nar, got.zero, got.scale, got.frac, got.g, got.r, got.s,
               exp.sign, exp.nar, exp.zero, exp.scale, exp.frac, exp.g, exp.r, exp.s);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b", name, got, exp);
    end
  endtask

  function automatic op_t mk(input bit s, input int sc, input int f);
    op_t o;
    o       = '0;
    o.sign  = s;
    o.scale = SW'(sc);
    o.frac  = FW'(f);
    return o;
  endfunction

  function automatic res_t mr(input bit s, input bit n, input bit z, input int sc,
                              input int f, input bit g, input bit r, input bit st);
    res_t x;
    x.sign = s; x.nar = n; x.zero = z; x.scale = (SW+1)'(sc);
    x.frac = FW'(f); x.g = g; x.r = r; x.s = st;
    return x;
  endfunction

  // Reference: values as integer significands (hidden bit + FW + 3 extra bits).
  function automatic res_t model(input op_t a, input op_t b, input bit sb);
    res_t   x;
    bit     bs, ls, ss, a_big;
    int     lsc, ssc, lf, sf, sh, sc, ka, kb;
    longint lm, sm, sa, sum;
    x  = '0;
    bs = b.sign ^ sb;
    if (a.nar || b.nar) begin
      x.nar = 1'b1;
    end else if (a.zero && b.zero) begin
      x.zero = 1'b1;
    end else if (a.zero) begin
      x.sign = bs; x.scale = (SW+1)'($signed(b.scale)); x.frac = b.frac;
    end else if (b.zero) begin
      x.sign = a.sign; x.scale = (SW+1)'($signed(a.scale)); x.frac = a.frac;
    end else begin
      ka = int'($signed(a.scale)) * (1 << FW) + int'(a.frac);
      kb = int'($signed(b.scale)) * (1 << FW) + int'(b.frac);
      a_big = (ka >= kb);
      ls  = a_big ? a.sign : bs;
      ss  = a_big ? bs : a.sign;
      lsc = a_big ? int'($signed(a.scale)) : int'($signed(b.scale));
      ssc = a_big ? int'($signed(b.scale)) : int'($signed(a.scale));
      lf  = a_big ? int'(a.frac) : int'(b.frac);
      sf  = a_big ? int'(b.frac) : int'(a.frac);
      sh  = lsc - ssc;
      if (sh > FW + 4) sh = FW + 4;
      lm = longint'((1 << FW) + lf) * 8;
      sm = longint'((1 << FW) + sf) * 8;
      sa = sm >> sh;
      if ((sm % (longint'(1) << sh)) != 0) sa = sa | 1;
      sum = (ls == ss) ? lm + sa : lm - sa;
      if (sum == 0) begin
        x.zero = 1'b1;
      end else begin
        sc = lsc;
        if (sum >= (longint'(1) << (FW + 4))) begin
          sum = (sum >> 1) | (sum & 1);
          sc  = sc + 1;
        end else begin
          while (sum < (longint'(1) << (FW + 3))) begin
            sum = sum * 2;
            sc  = sc - 1;
          end
        end
        x.sign  = ls;
        x.scale = (SW+1)'(sc);
        x.frac  = FW'((sum >> 3) % (1 << FW));
        x.g     = sum[2];
        x.r     = sum[1];
        x.s     = sum[0];
      end
    end
    return x;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int  k;
    k       = int'($urandom_range(0, 19));
    o.sign  = 1'($urandom_range(0, 1));
    o.scale = SW'(int'($urandom_range(0, 24)) - 12);
    o.frac  = FW'($urandom_range(0, (1 << FW) - 1));
    o.nar   = (k == 0);
    o.zero  = (k == 1);
    return o;
  endfunction

  // Downstream readiness
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: scoreboard on accept/emit, hold checks while stalled
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk_b("stall_valid", out_valid, 1'b1);
        if (out_valid) chk_r("stall_hold", cur, held);
      end
      held_v = out_valid && !out_ready;
      held   = cur;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out got an output expected none");
        end else begin
          exp_r = q.pop_front();
          chk_r("result", cur, exp_r);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a_in, b_in, sub));
    end
  end

  task automatic send(input op_t a, input op_t b, input bit s);
    int n;
    bit acc;
    n = 0;
    op1_sign = a.sign; op1_nar = a.nar; op1_zero = a.zero;
    op1_scale = a.scale; op1_fraction = a.frac;
    op2_sign = b.sign; op2_nar = b.nar; op2_zero = b.zero;
    op2_scale = b.scale; op2_fraction = b.frac;
    sub = s;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no in_ready expected accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  op_t one, one5, m_one, m125, p125, e8, e5, m3, zop, nop, a, b;

  initial begin
    one  = mk(0, 0, 0);
    one5 = mk(0, 0, 8);
    m_one = mk(1, 0, 0);
    m125 = mk(1, 0, 4);
    p125 = mk(0, 0, 4);
    e8   = mk(0, -8, 0);
    e5   = mk(0, -5, 0);
    m3   = mk(1, 1, 8);
    zop  = '0; zop.zero = 1'b1;
    nop  = '0; nop.nar = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_r("rst_outputs", cur, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_b("post_rst_in_ready", in_ready, 1'b1);

    // Hand-computed expectations pin the model
    chk_r("pin_1p1",      model(one, one, 0),   mr(0, 0, 0, 1, 0, 0, 0, 0));
    chk_r("pin_1p5_m1",   model(one5, m_one, 0), mr(0, 0, 0, -1, 0, 0, 0, 0));
    chk_r("pin_1p5_sub1", model(one5, one, 1),  mr(0, 0, 0, -1, 0, 0, 0, 0));
    chk_r("pin_1m1",      model(one, one, 1),   mr(0, 0, 1, 0, 0, 0, 0, 0));
    chk_r("pin_m125p125", model(m125, p125, 0), mr(0, 0, 1, 0, 0, 0, 0, 0));
    chk_r("pin_1_e8",     model(one, e8, 0),    mr(0, 0, 0, 0, 0, 0, 0, 1));
    chk_r("pin_1_e5",     model(one, e5, 0),    mr(0, 0, 0, 0, 0, 1, 0, 0));
    chk_r("pin_nar",      model(nop, m3, 0),    mr(0, 1, 0, 0, 0, 0, 0, 0));
    chk_r("pin_zero_m3",  model(zop, m3, 0),    mr(1, 0, 0, 1, 8, 0, 0, 0));
    chk_r("pin_zero_zero", model(zop, zop, 1),  mr(0, 0, 1, 0, 0, 0, 0, 0));

    // Directed operations through the DUT
    ready_mode = 0;
    send(one, one, 0);
    send(one5, m_one, 0);
    send(one5, one, 1);
    send(one, one, 1);
    send(m125, p125, 0);
    send(one, e8, 0);
    send(one, e5, 0);
    send(nop, m3, 0);
    send(zop, m3, 0);
    send(m3, zop, 1);
    send(zop, zop, 0);
    drain();

    // Eight back-to-back with out_ready cycling 1,0,0,1
    ready_mode = 1;
    pidx = 0;
    for (int i = 0; i < 8; i++) begin
      a = rnd_op();
      b = rnd_op();
      send(a, b, 1'($urandom_range(0, 1)));
    end
    drain();

    // Random stream with random gaps and backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      a = rnd_op();
      b = rnd_op();
      if ($urandom_range(0, 3) == 0) begin
        b = a;
        b.frac = b.frac ^ FW'($urandom_range(0, 1));
        b.sign = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(a, b, 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset in the middle of a running stream
    ready_mode = 0;
    send(one, one, 0);
    send(one5, m_one, 0);
    send(one, e5, 0);
    send(m3, one, 0);
    chk_b("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    q.delete();
    #1;
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_b("mid_rst_in_ready", in_ready, 1'b1);
    chk_r("mid_rst_outputs", cur, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_b("post_rst_no_output", out_valid, 1'b0);
      chk_b("post_rst_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    send(m3, one, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
